// File: rtl/ff_apb_timer.sv
// ff_apb_timer: APB programmable down-counting timer with prescaler,
// auto-reload and a level interrupt. Zero-wait-state slave.
//
// Optional feature: define FF_APB_TIMER_CAPTURE_EN to add the capture input,
// the CAPTURE register (0x10) and STATUS[1] CAPTURED.
//
// Register map (paddr[4:2]):
//   0x00 CTRL    RW  [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN, [8+:PRESCALE_W] PRESCALE
//   0x04 LOAD    RW  reload value; a write also loads COUNT and clears the prescaler
//   0x08 COUNT   RO  current count
//   0x0C STATUS  W1C [0] EXPIRED, [1] CAPTURED
//   0x10 CAPTURE RO  COUNT latched on a capture rising edge
module ff_apb_timer #(
  parameter int WIDTH      = 32,
  parameter int PRESCALE_W = 8
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic [19:0] paddr,
  input  logic        pwrite,
  input  logic        psel,
  input  logic        penable,
  input  logic [31:0] pwdata,
`ifdef FF_APB_TIMER_CAPTURE_EN
  input  logic        capture,
`endif
  output logic [31:0] prdata,
  output logic        irq
);

  localparam logic [2:0] OFS_CTRL    = 3'd0;
  localparam logic [2:0] OFS_LOAD    = 3'd1;
  localparam logic [2:0] OFS_COUNT   = 3'd2;
  localparam logic [2:0] OFS_STATUS  = 3'd3;
  localparam logic [2:0] OFS_CAPTURE = 3'd4;

  logic                  en;
  logic                  auto_reload;
  logic                  irq_en;
  logic [PRESCALE_W-1:0] prescale;
  logic [WIDTH-1:0]      load;
  logic [WIDTH-1:0]      count;
  logic [PRESCALE_W-1:0] pcnt;
  logic                  expired;
  logic                  captured;
  logic [WIDTH-1:0]      capture_q;

  logic [2:0] addr;
  logic       wr_en;
  logic       ctrl_wr;
  logic       load_wr;
  logic       status_wr;
  logic       tick;
  logic       tick_eff;
  logic       expire;

  assign addr      = paddr[4:2];
  assign wr_en     = psel & penable & pwrite;
  assign ctrl_wr   = wr_en & (addr == OFS_CTRL);
  assign load_wr   = wr_en & (addr == OFS_LOAD);
  assign status_wr = wr_en & (addr == OFS_STATUS);

  // A tick is suppressed when a LOAD write or an EN-clearing CTRL write lands
  // on the same edge: the bus write has priority over the counter.
  assign tick     = en & (pcnt == prescale);
  assign tick_eff = tick & ~load_wr & ~(ctrl_wr & ~pwdata[0]);
  assign expire   = tick_eff & (count == '0);

  // Only paddr[4:2] is decoded and pwdata above the register widths is dropped.
  logic unused_bits;
  assign unused_bits = ^{paddr[19:5], paddr[1:0], pwdata};

  // CTRL register: bus writes win over the one-shot auto-disable.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      en          <= 1'b0;
      auto_reload <= 1'b0;
      irq_en      <= 1'b0;
      prescale    <= '0;
    end else if (ctrl_wr) begin
      en          <= pwdata[0];
      auto_reload <= pwdata[1];
      irq_en      <= pwdata[2];
      prescale    <= pwdata[8 +: PRESCALE_W];
    end else if (expire && !auto_reload) begin
      en <= 1'b0;
    end
  end

  // LOAD register.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      load <= '0;
    end else if (load_wr) begin
      load <= pwdata[WIDTH-1:0];
    end
  end

  // Prescaler: free-runs 0..PRESCALE while enabled; cleared on LOAD writes,
  // on an EN 0->1 or EN-clearing CTRL write, and whenever disabled.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      pcnt <= '0;
    end else if (load_wr || !en || tick || (ctrl_wr && !(en && pwdata[0]))) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // Down counter: LOAD write first, then decrement / reload on a tick.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      count <= '0;
    end else if (load_wr) begin
      count <= pwdata[WIDTH-1:0];
    end else if (tick_eff) begin
      if (count != '0) begin
        count <= count - 1'b1;
      end else if (auto_reload) begin
        count <= load;
      end
    end
  end

  // EXPIRED flag: set beats a simultaneous write-1-to-clear.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      expired <= 1'b0;
    end else if (expire) begin
      expired <= 1'b1;
    end else if (status_wr && pwdata[0]) begin
      expired <= 1'b0;
    end
  end

`ifdef FF_APB_TIMER_CAPTURE_EN
  logic cap_s1;
  logic cap_s2;
  logic cap_s3;
  logic cap_rise;

  assign cap_rise = cap_s2 & ~cap_s3;

  // Two-flop synchroniser plus one delay flop for rising-edge detection.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cap_s1 <= 1'b0;
      cap_s2 <= 1'b0;
      cap_s3 <= 1'b0;
    end else begin
      cap_s1 <= capture;
      cap_s2 <= cap_s1;
      cap_s3 <= cap_s2;
    end
  end

  // CAPTURE register and CAPTURED flag; set beats a simultaneous clear.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      capture_q <= '0;
      captured  <= 1'b0;
    end else if (cap_rise) begin
      capture_q <= count;
      captured  <= 1'b1;
    end else if (status_wr && pwdata[1]) begin
      captured  <= 1'b0;
    end
  end
`else
  assign capture_q = '0;
  assign captured  = 1'b0;
`endif

  assign irq = irq_en & (expired | captured);

  // Read mux: combinational, valid through setup and access phases.
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    prdata = '0;
    if (psel) begin
      case (addr)
        OFS_CTRL: begin
          prdata[0]               = en;
          prdata[1]               = auto_reload;
          prdata[2]               = irq_en;
          prdata[8 +: PRESCALE_W] = prescale;
        end
        OFS_LOAD:    prdata[WIDTH-1:0] = load;
        OFS_COUNT:   prdata[WIDTH-1:0] = count;
        OFS_STATUS:  prdata[1:0]       = {captured, expired};
        OFS_CAPTURE: prdata[WIDTH-1:0] = capture_q;
        default:     prdata            = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ff_apb_timer.sv
// Directed self-checking bench for ff_apb_timer. Expected values are
// hand-computed from the register/timing behaviour of the timer.
// Define FF_APB_TIMER_CAPTURE_EN to also exercise the capture feature.
module tb_ff_apb_timer;

  localparam logic [19:0] A_CTRL    = 20'h00;
  localparam logic [19:0] A_LOAD    = 20'h04;
  localparam logic [19:0] A_COUNT   = 20'h08;
  localparam logic [19:0] A_STATUS  = 20'h0C;
  localparam logic [19:0] A_CAPTURE = 20'h10;
  localparam logic [19:0] A_UNMAP   = 20'h1C;

  logic        pclk = 1'b0;
  logic        presetn;
  logic [19:0] paddr;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        irq;
`ifdef FF_APB_TIMER_CAPTURE_EN
  logic        capture;
`endif

  int n_cmp = 0;
  int n_err = 0;

  ff_apb_timer #(.WIDTH(32), .PRESCALE_W(8)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .paddr   (paddr),
    .pwrite  (pwrite),
    .psel    (psel),
    .penable (penable),
    .pwdata  (pwdata),
`ifdef FF_APB_TIMER_CAPTURE_EN
    .capture (capture),
`endif
    .prdata  (prdata),
    .irq     (irq)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Setup-phase read between clock edges: no side effects, no clock consumed.
  task automatic peek(input logic [19:0] addr, output logic [31:0] data);
    psel    = 1'b1;
    pwrite  = 1'b0;
    penable = 1'b0;
    paddr   = addr;
    #1;
    data = prdata;
    psel = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [19:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    peek(addr, d);
    chk(tag, d, exp);
  endtask

  // Full APB write; returns 1 time unit after the write (access-end) edge.
  task automatic apb_write(input logic [19:0] addr, input logic [31:0] data);
    @(negedge pclk);
    psel    = 1'b1;
    pwrite  = 1'b1;
    penable = 1'b0;
    paddr   = addr;
    pwdata  = data;
    @(negedge pclk);
    penable = 1'b1;
    @(posedge pclk);
    #1;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
  endtask

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    presetn = 1'b0;
    paddr   = '0;
    pwrite  = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    pwdata  = '0;
`ifdef FF_APB_TIMER_CAPTURE_EN
    capture = 1'b0;
`endif
    #1;
    chk("reset_prdata_psel_low", prdata, 32'h0);
    chk("reset_irq", {31'h0, irq}, 32'h0);
    step(2);
    @(negedge pclk);
    presetn = 1'b1;
    step(1);

    // Reset values and unmapped offset.
    chk_reg("rst_ctrl",   A_CTRL,   32'h0);
    chk_reg("rst_load",   A_LOAD,   32'h0);
    chk_reg("rst_count",  A_COUNT,  32'h0);
    chk_reg("rst_status", A_STATUS, 32'h0);
    chk_reg("rst_unmap",  A_UNMAP,  32'h0);
    chk_reg("rst_cap",    A_CAPTURE, 32'h0);

    // Setup phase alone must not write.
    @(negedge pclk);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = A_LOAD; pwdata = 32'h55;
    @(negedge pclk);
    psel = 1'b0; pwrite = 1'b0;
    step(1);
    chk_reg("setup_no_write", A_LOAD, 32'h0);

    // COUNT is read-only.
    apb_write(A_COUNT, 32'h1234);
    chk_reg("count_ro", A_COUNT, 32'h0);

    // Auto-reload, PRESCALE=0, LOAD=3: expiry 4 edges after the CTRL write.
    apb_write(A_LOAD, 32'd3);
    chk_reg("load_sets_count", A_COUNT, 32'd3);
    apb_write(A_CTRL, 32'h3);                       // E0
    chk_reg("ar_count_e0", A_COUNT, 32'd3);
    step(1); chk_reg("ar_count_e1", A_COUNT, 32'd2);
    step(1); chk_reg("ar_count_e2", A_COUNT, 32'd1);
    step(1); chk_reg("ar_count_e3", A_COUNT, 32'd0);
    chk_reg("ar_status_e3", A_STATUS, 32'h0);
    step(1); chk_reg("ar_status_e4", A_STATUS, 32'h1);
    chk_reg("ar_reload_e4", A_COUNT, 32'd3);
    chk("ar_irq_masked", {31'h0, irq}, 32'h0);
    apb_write(A_STATUS, 32'h1);                     // E6
    chk_reg("ar_w1c_e6", A_STATUS, 32'h0);
    chk_reg("ar_count_e6", A_COUNT, 32'd1);
    step(1); chk_reg("ar_status_e7", A_STATUS, 32'h0);
    step(1); chk_reg("ar_status_e8", A_STATUS, 32'h1);
    chk_reg("ar_reload_e8", A_COUNT, 32'd3);
    apb_write(A_CTRL, 32'h0);
    apb_write(A_STATUS, 32'h1);
    chk_reg("ar_cleared", A_STATUS, 32'h0);

    // One-shot, IRQ_EN, PRESCALE=2, LOAD=1: irq 6 edges after the write.
    apb_write(A_LOAD, 32'd1);
    apb_write(A_CTRL, 32'h0205);                    // E0
    step(2); chk_reg("os_count_e2", A_COUNT, 32'd1);
    step(1); chk_reg("os_count_e3", A_COUNT, 32'd0);
    step(2); chk("os_irq_e5", {31'h0, irq}, 32'h0);
    step(1); chk("os_irq_e6", {31'h0, irq}, 32'h1);
    chk_reg("os_status_e6", A_STATUS, 32'h1);
    chk_reg("os_ctrl_en_off", A_CTRL, 32'h0204);
    step(3); chk_reg("os_count_stays", A_COUNT, 32'd0);
    apb_write(A_STATUS, 32'h1);
    chk("os_irq_cleared", {31'h0, irq}, 32'h0);

    // W1C on the expiry edge, LOAD write on a tick, EN clear on a tick.
    apb_write(A_LOAD, 32'd3);
    apb_write(A_CTRL, 32'h3);                       // E0
    step(2);
    apb_write(A_STATUS, 32'h1);                     // E4 = expiry edge
    chk_reg("w1c_vs_set", A_STATUS, 32'h1);
    chk_reg("w1c_vs_set_count", A_COUNT, 32'd3);
    apb_write(A_STATUS, 32'h1);                     // E6
    chk_reg("w1c_second", A_STATUS, 32'h0);
    chk_reg("w1c_count_e6", A_COUNT, 32'd1);
    apb_write(A_LOAD, 32'd5);                       // E8, would have expired
    chk_reg("loadwr_wins_count", A_COUNT, 32'd5);
    chk_reg("loadwr_no_expiry", A_STATUS, 32'h0);
    step(1); chk_reg("loadwr_next_tick", A_COUNT, 32'd4);
    apb_write(A_CTRL, 32'h0);                       // E11, tick suppressed
    chk_reg("endis_no_dec", A_COUNT, 32'd3);
    step(2); chk_reg("endis_holds", A_COUNT, 32'd3);

`ifdef FF_APB_TIMER_CAPTURE_EN
    // Capture at COUNT=5 with PRESCALE=7; latched 3 edges after the rise.
    apb_write(A_LOAD, 32'd5);
    apb_write(A_CTRL, 32'h0705);                    // E0
    capture = 1'b1;
    step(2); chk_reg("cap_not_yet", A_STATUS, 32'h0);
    step(1);
    capture = 1'b0;
    chk_reg("cap_value", A_CAPTURE, 32'd5);
    chk_reg("cap_status", A_STATUS, 32'h2);
    chk("cap_irq", {31'h0, irq}, 32'h1);
    apb_write(A_STATUS, 32'h2);
    chk_reg("cap_w1c", A_STATUS, 32'h0);
    chk("cap_irq_clear", {31'h0, irq}, 32'h0);
    apb_write(A_CTRL, 32'h0);
`endif

    // Reset while counting from 0x10 with IRQ_EN.
    apb_write(A_LOAD, 32'h10);
    apb_write(A_CTRL, 32'h5);                       // E0
    step(3); chk_reg("pre_rst_count", A_COUNT, 32'hD);
    #2;
    presetn = 1'b0;
    #1;
    chk("rst_mid_irq", {31'h0, irq}, 32'h0);
    chk_reg("rst_mid_count", A_COUNT, 32'h0);
    @(negedge pclk);
    presetn = 1'b1;
    step(1);
    chk_reg("post_rst_ctrl",   A_CTRL,   32'h0);
    chk_reg("post_rst_load",   A_LOAD,   32'h0);
    chk_reg("post_rst_count",  A_COUNT,  32'h0);
    chk_reg("post_rst_status", A_STATUS, 32'h0);
    step(20);
    chk_reg("post_rst_idle_count", A_COUNT, 32'h0);
    chk("post_rst_irq", {31'h0, irq}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
